// File: rtl/fix_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fix_mult_pipe
// Description : Three-stage pipelined sign-magnitude fixed-point multiplier.
//               Inputs and outputs are N-bit sign-magnitude words with Q
//               fractional bits. The block offers selectable round-half-up
//               or truncation, saturation or wrap on overflow, an overflow
//               flag, and valid/ready flow control with backpressure.
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module fix_mult_pipe #(
  parameter int Q     = 8,   // fractional bits, 1 <= Q <= N-2
  parameter int N     = 16,  // total width including sign, N >= 4
  parameter int ROUND = 1,   // 1 = round half up on magnitude, 0 = truncate
  parameter int SAT   = 1    // 1 = clamp magnitude on overflow, 0 = wrap
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  // Magnitude width and full-precision product width. PW is exactly twice
  // MW, so the unsigned magnitude product always fits without truncation.
  localparam int MW = N - 1;
  localparam int PW = 2 * N - 2;

  // Rounding increment, one bit wider than the product so the add can
  // never drop a carry out of the top bit.
  localparam logic [PW:0]   RND_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   RND_ADD = (ROUND != 0) ? (RND_ONE << (Q - 1)) : '0;
  localparam logic [MW-1:0] MAG_MAX = '1;

  // --------------------------------------------------------------------------
  // Pipeline control
  // --------------------------------------------------------------------------
  // The whole pipe moves together: it advances whenever the output register
  // is empty or is being drained this cycle. Bubbles move with the data,
  // which keeps capacity at exactly three words.
  logic en;

  logic s1_valid;
  logic s2_valid;
  logic s3_valid;

  // Stage 1 data: result sign and the two operand magnitudes
  logic          s1_sign;
  logic [MW-1:0] s1_ma;
  logic [MW-1:0] s1_mb;

  // Stage 2 data: sign and full-precision magnitude product (2Q frac bits)
  logic          s2_sign;
  logic [PW-1:0] s2_prod;

  // Stage 3 data: final sign-magnitude word and overflow flag
  logic [N-1:0]  s3_c;
  logic          s3_ovf;

  assign en        = ~s3_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid;
  assign c         = s3_c;
  assign ovf       = s3_ovf;

  // --------------------------------------------------------------------------
  // Stage 1 input decode
  // --------------------------------------------------------------------------
  logic [MW-1:0] in_ma;
  logic [MW-1:0] in_mb;
  logic          in_zero;
  logic          in_sign;

  // Split operands into magnitudes and a product sign; a zero operand
  // (including negative zero) forces a positive sign.
  always_comb begin
    in_ma   = a[MW-1:0];
    in_mb   = b[MW-1:0];
    in_zero = (in_ma == '0) || (in_mb == '0);
    in_sign = (a[N-1] ^ b[N-1]) & ~in_zero;
  end

  // --------------------------------------------------------------------------
  // Stage 2 multiply
  // --------------------------------------------------------------------------
  logic [PW-1:0] mul_prod;

  // Unsigned magnitude product at full precision.
  always_comb begin
    mul_prod = PW'(s1_ma) * PW'(s1_mb);
  end

  // --------------------------------------------------------------------------
  // Stage 3 rescale, overflow detect and saturation
  // --------------------------------------------------------------------------
  logic [PW:0]   rnd_sum;
  logic [PW:0]   rsh;
  logic          r_ovf;
  logic [MW-1:0] r_low;
  logic [MW-1:0] r_mag;
  logic [N-1:0]  r_word;

  // Round (or truncate) back to Q fractional bits; anything left above the
  // magnitude field means the result does not fit in N-1 bits.
  always_comb begin
    rnd_sum = {1'b0, s2_prod} + RND_ADD;
    rsh     = rnd_sum >> Q;
    r_ovf   = |rsh[PW:MW];
    r_low   = rsh[MW-1:0];
  end

  generate
    if (SAT != 0) begin : g_sat
      // Clamp the magnitude to full scale when the product overflows.
      always_comb begin
        r_mag = r_ovf ? MAG_MAX : r_low;
      end
    end else begin : g_wrap
      // Keep only the low magnitude bits; overflow is still flagged.
      always_comb begin
        r_mag = r_low;
      end
    end
  endgenerate

  // Assemble the output word; a zero magnitude never carries a minus sign.
  always_comb begin
    r_word = {s2_sign & (r_mag != '0), r_mag};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Valid bits shift as one chain whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Stage 1 data captures only real input words so idle cycles do not toggle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (en && in_valid) begin
      s1_sign <= in_sign;
      s1_ma   <= in_ma;
      s1_mb   <= in_mb;
    end
  end

  // Stage 2 data captures the product of a valid stage 1 word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign <= 1'b0;
      s2_prod <= '0;
    end else if (en && s1_valid) begin
      s2_sign <= s1_sign;
      s2_prod <= mul_prod;
    end
  end

  // Output register; holds its word while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_c   <= '0;
      s3_ovf <= 1'b0;
    end else if (en && s2_valid) begin
      s3_c   <= r_word;
      s3_ovf <= r_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix_mult_pipe
// Description : Directed and scoreboarded bench for fix_mult_pipe. Three
//               instances share stimulus: default (round, saturate), a
//               truncating one and a wrapping one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;

  logic        in_ready,    out_valid,    ovf;
  logic [15:0] c;
  logic        in_ready_r0, out_valid_r0, ovf_r0;
  logic [15:0] c_r0;
  logic        in_ready_s0, out_valid_s0, ovf_s0;
  logic [15:0] c_s0;

  always #5 clk = ~clk;

  fix_mult_pipe #(.Q(8), .N(16), .ROUND(1), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf));

  fix_mult_pipe #(.Q(8), .N(16), .ROUND(0), .SAT(1)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r0),
    .a(a), .b(b), .out_valid(out_valid_r0), .out_ready(out_ready),
    .c(c_r0), .ovf(ovf_r0));

  fix_mult_pipe #(.Q(8), .N(16), .ROUND(1), .SAT(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s0),
    .a(a), .b(b), .out_valid(out_valid_s0), .out_ready(out_ready),
    .c(c_s0), .ovf(ovf_s0));

  typedef struct packed {
    logic [15:0] c;
    logic        ovf;
    logic [15:0] c_r0;
    logic        ovf_r0;
    logic [15:0] c_s0;
    logic        ovf_s0;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass;
  int          n_total;
  int          n_out;
  logic        hold_pending;
  logic [15:0] hold_c;
  logic        hold_ovf;
  logic        last_in_ready;

  logic [15:0] bp_a [6] = '{16'h0180, 16'h8180, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0300};
  logic [15:0] bp_b [6] = '{16'h0200, 16'h0200, 16'h0080, 16'h0200, 16'h0200, 16'h8100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Q8.16 sign-magnitude reference using plain integer arithmetic
  function automatic logic [16:0] model(input logic [15:0] va, input logic [15:0] vb,
                                        input int round, input int sat);
    longint unsigned ma, mb, p, r, mag;
    logic            o;
    logic            sg;
    ma  = va[14:0];
    mb  = vb[14:0];
    p   = ma * mb;
    r   = (p + ((round != 0) ? 64'd128 : 64'd0)) / 256;
    o   = (r > 32767);
    if (o) mag = (sat != 0) ? 64'd32767 : (r % 32768);
    else   mag = r;
    sg  = (va[15] ^ vb[15]) && (mag != 0);
    return {o, sg, mag[14:0]};
  endfunction

  // One clock of streaming with scoreboard and stall-stability checks
  task automatic cycle(input logic iv, input logic [15:0] va, input logic [15:0] vb,
                       input logic ordy, output logic acc);
    exp_t        e;
    exp_t        g;
    logic [16:0] m;
    in_valid  = iv;
    a         = va;
    b         = vb;
    out_ready = ordy;
    #1;
    if (hold_pending) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_c",     32'(c),         32'(hold_c));
      chk("stall_ovf",   32'(ovf),       32'(hold_ovf));
    end
    hold_pending  = out_valid && !out_ready;
    hold_c        = c;
    hold_ovf      = ovf;
    last_in_ready = in_ready;
    acc           = iv && in_ready;
    if (acc) begin
      m = model(va, vb, 1, 1); e.c    = m[15:0]; e.ovf    = m[16];
      m = model(va, vb, 0, 1); e.c_r0 = m[15:0]; e.ovf_r0 = m[16];
      m = model(va, vb, 1, 0); e.c_s0 = m[15:0]; e.ovf_s0 = m[16];
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        g = exp_q.pop_front();
        chk("sb_c",      32'(c),      32'(g.c));
        chk("sb_ovf",    32'(ovf),    32'(g.ovf));
        chk("sb_c_r0",   32'(c_r0),   32'(g.c_r0));
        chk("sb_ovf_r0", 32'(ovf_r0), 32'(g.ovf_r0));
        chk("sb_c_s0",   32'(c_s0),   32'(g.c_s0));
        chk("sb_ovf_s0", 32'(ovf_s0), 32'(g.ovf_s0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated transaction with exact latency check
  task automatic vec(input string id, input logic [15:0] va, input logic [15:0] vb,
                     input logic [15:0] ec, input logic eo,
                     input logic [15:0] ec_r0, input logic [15:0] ec_s0);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = 1'b1;
    #1;
    chk($sformatf("%s_in_ready", id), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    @(posedge clk); #1;
    chk($sformatf("%s_lat2_valid", id), 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("%s_lat3_valid", id), 32'(out_valid), 32'd1);
    chk($sformatf("%s_c", id),          32'(c),         32'(ec));
    chk($sformatf("%s_ovf", id),        32'(ovf),       32'(eo));
    chk($sformatf("%s_c_r0", id),       32'(c_r0),      32'(ec_r0));
    chk($sformatf("%s_ovf_r0", id),     32'(ovf_r0),    32'(eo));
    chk($sformatf("%s_c_s0", id),       32'(c_s0),      32'(ec_s0));
    chk($sformatf("%s_ovf_s0", id),     32'(ovf_s0),    32'(eo));
    @(posedge clk); #1;
    chk($sformatf("%s_drain_valid", id), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        ordy;
    logic        pending;
    logic        saw_low;
    logic [15:0] va;
    logic [15:0] vb;
    int          idx;
    int          stall;
    int          sent;

    n_pass       = 0;
    n_total      = 0;
    n_out        = 0;
    hold_pending = 1'b0;
    hold_c       = 16'h0;
    hold_ovf     = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    a            = 16'h0;
    b            = 16'h0;
    out_ready    = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c",         32'(c),         32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready",  32'(in_ready),  32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed vectors: id, a, b, c(round,sat), ovf, c(trunc), c(wrap)
    vec("v_1p5x2",   16'h0180, 16'h0200, 16'h0300, 1'b0, 16'h0300, 16'h0300);
    vec("v_neg",     16'h8180, 16'h0200, 16'h8300, 1'b0, 16'h8300, 16'h8300);
    vec("v_round",   16'h0001, 16'h0080, 16'h0001, 1'b0, 16'h0000, 16'h0001);
    vec("v_negzero", 16'h8001, 16'h0080, 16'h8001, 1'b0, 16'h0000, 16'h8001);
    vec("v_ovf_pos", 16'h7FFF, 16'h0200, 16'h7FFF, 1'b1, 16'h7FFF, 16'h7FFE);
    vec("v_ovf_neg", 16'hFFFF, 16'h0200, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFE);
    vec("v_inzero",  16'h8000, 16'h0100, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    vec("v_negneg",  16'h8100, 16'h8100, 16'h0100, 1'b0, 16'h0100, 16'h0100);

    // Backpressure: six back-to-back words, four stall cycles after first output
    hold_pending = 1'b0;
    n_out        = 0;
    idx          = 0;
    stall        = 0;
    saw_low      = 1'b0;
    for (int cyc = 0; cyc < 60 && (idx < 6 || exp_q.size() != 0); cyc++) begin
      ordy = !(n_out >= 1 && stall < 4);
      if (!ordy) stall++;
      pending = (idx < 6);
      if (pending) begin
        va = bp_a[idx];
        vb = bp_b[idx];
      end else begin
        va = 16'h0;
        vb = 16'h0;
      end
      cycle(pending, va, vb, ordy, acc);
      if (pending && !last_in_ready) saw_low = 1'b1;
      if (acc) idx++;
    end
    chk("bp_outputs",        32'(n_out),        32'd6);
    chk("bp_in_ready_fell",  32'(saw_low),      32'd1);
    chk("bp_sb_empty",       32'(exp_q.size()), 32'd0);

    // Random streaming with random valid/ready
    hold_pending = 1'b0;
    n_out        = 0;
    sent         = 0;
    for (int cyc = 0; cyc < 3000 && (sent < 100 || exp_q.size() != 0); cyc++) begin
      pending = (sent < 100) && ($urandom_range(0, 3) != 0);
      ordy    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) va = 16'($urandom);
      else va = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 4095))};
      if ($urandom_range(0, 1) != 0) vb = 16'($urandom);
      else vb = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 4095))};
      cycle(pending, va, vb, ordy, acc);
      if (acc) sent++;
    end
    chk("rand_sent",     32'(sent),         32'd100);
    chk("rand_outputs",  32'(n_out),        32'd100);
    chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three words in flight
    hold_pending = 1'b0;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    a = 16'h0180; b = 16'h0200;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0080;
    @(posedge clk); #1;
    a = 16'h8180; b = 16'h0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid",    32'(out_valid), 32'd1);
    chk("mid_full_c",        32'(c),         32'h0300);
    chk("mid_full_in_ready", 32'(in_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_c",         32'(c),         32'd0);
    chk("mid_rst_ovf",       32'(ovf),       32'd0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_old_%0d", i), 32'(out_valid), 32'd0);
    end
    vec("v_post_rst", 16'h0200, 16'h0300, 16'h0600, 1'b0, 16'h0600, 16'h0600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
